pong_game_ctrl: RTL and testbench

- Top-level game sequencer for the pong design.
- Generates the frame-rate movement tick and gates the ball datapath (load, run).
- Detects misses at the left/right screen edges and keeps both scores.
- Steps through serve, play, point-hold and game-over phases. The ball mover, human paddle and AI paddle consume its TICK/BALL_RUN/BALL_LOAD strobes.

---
 rtl/pong_game_ctrl.sv | 151 +++++++++++++++
 tb/tb_pong_game_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: movement tick divider, serve/play/point/over phases,
// edge-miss detection and score keeping for both players.
module pong_game_ctrl #(
  parameter int TICK_DIV    = 500000,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 90,
  parameter int WIN_SCORE   = 9,
  parameter int LEFT_EDGE   = 0,
  parameter int RIGHT_EDGE  = 799
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        PAUSE,
  input  logic [10:0] BALL_H,
  output logic        TICK,
  output logic        BALL_LOAD,
  output logic        BALL_RUN,
  output logic        SERVE_DIR,
  output logic [3:0]  SCORE_L,
  output logic [3:0]  SCORE_R,
  output logic        WINNER,
  output logic [2:0]  STATE
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam int TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_MAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] SERVE_LAST = PW'(SERVE_TICKS - 1);
  localparam logic [PW-1:0] POINT_LAST = PW'(POINT_TICKS - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
  localparam logic [10:0]   L_EDGE     = 11'(LEFT_EDGE);
  localparam logic [10:0]   R_EDGE     = 11'(RIGHT_EDGE);

  state_t        state, state_nx;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] phase, phase_nx;
  logic [3:0]    score_l, score_l_nx, score_r, score_r_nx;
  logic          dir, dir_nx, winner, winner_nx, ball_load;

  // Free-running divider; PAUSE freezes it so the countdowns freeze too.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)
      tick_cnt <= '0;
    else if (!PAUSE)
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
  end

  assign TICK = (tick_cnt == TICK_LAST) && !PAUSE;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    phase_nx   = phase;
    score_l_nx = score_l;
    score_r_nx = score_r;
    dir_nx     = dir;
    winner_nx  = winner;
    case (state)
      IDLE, OVER: begin
        if (START) begin
          state_nx   = SERVE;
          phase_nx   = '0;
          score_l_nx = '0;
          score_r_nx = '0;
          dir_nx     = 1'b0;
          winner_nx  = 1'b0;
        end
      end
      SERVE: begin
        if (TICK) begin
          if (phase == SERVE_LAST) begin
            state_nx = PLAY;
            phase_nx = '0;
          end else begin
            phase_nx = phase + 1'b1;
          end
        end
      end
      PLAY: begin
        // Left miss wins ties; leaving PLAY guarantees one miss per point.
        if (BALL_H <= L_EDGE) begin
          score_r_nx = (score_r == WIN) ? score_r : score_r + 4'd1;
          dir_nx     = 1'b0;
          state_nx   = POINT;
          phase_nx   = '0;
        end else if (BALL_H >= R_EDGE) begin
          score_l_nx = (score_l == WIN) ? score_l : score_l + 4'd1;
          dir_nx     = 1'b1;
          state_nx   = POINT;
          phase_nx   = '0;
        end
      end
      POINT: begin
        if (score_l == WIN || score_r == WIN) begin
          state_nx  = OVER;
          winner_nx = (score_r == WIN);
        end else if (TICK) begin
          if (phase == POINT_LAST) begin
            state_nx = SERVE;
            phase_nx = '0;
          end else begin
            phase_nx = phase + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      phase     <= '0;
      score_l   <= '0;
      score_r   <= '0;
      dir       <= 1'b0;
      winner    <= 1'b0;
      ball_load <= 1'b0;
    end else begin
      phase     <= phase_nx;
      score_l   <= score_l_nx;
      score_r   <= score_r_nx;
      dir       <= dir_nx;
      winner    <= winner_nx;
      ball_load <= (state_nx == SERVE) && (state != SERVE);
    end
  end

  assign BALL_LOAD = ball_load;
  assign BALL_RUN  = (state == PLAY);
  assign SERVE_DIR = dir;
  assign SCORE_L   = score_l;
  assign SCORE_R   = score_r;
  assign WINNER    = winner;
  assign STATE     = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a 4-cycle tick, 3-tick serve,
// 2-tick point hold and a game won at 3 points.
module tb_pong_game_ctrl;
  logic        CLOCK = 1'b0;
  logic        RESET_N, START, PAUSE;
  logic [10:0] BALL_H;
  logic        TICK, BALL_LOAD, BALL_RUN, SERVE_DIR, WINNER;
  logic [3:0]  SCORE_L, SCORE_R;
  logic [2:0]  STATE;

  int total = 0;
  int bad   = 0;

  pong_game_ctrl #(
    .TICK_DIV(4), .SERVE_TICKS(3), .POINT_TICKS(2), .WIN_SCORE(3),
    .LEFT_EDGE(0), .RIGHT_EDGE(799)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .PAUSE(PAUSE),
    .BALL_H(BALL_H), .TICK(TICK), .BALL_LOAD(BALL_LOAD), .BALL_RUN(BALL_RUN),
    .SERVE_DIR(SERVE_DIR), .SCORE_L(SCORE_L), .SCORE_R(SCORE_R),
    .WINNER(WINNER), .STATE(STATE)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  // Called on the first POINT cycle (divider count 1): hold lasts 7 cycles.
  task automatic point_to_serve();
    step(6);
    chk("point_hold", 32'(STATE), 32'd3);
    step();
    chk("point_to_serve", 32'(STATE), 32'd1);
    chk("serve_load", 32'(BALL_LOAD), 32'd1);
  endtask

  // Called on the first SERVE cycle (divider count 0): serve lasts 12 cycles.
  task automatic serve_to_play();
    step(11);
    chk("serve_hold", 32'(STATE), 32'd1);
    step();
    chk("serve_to_play", 32'(STATE), 32'd2);
    chk("play_run", 32'(BALL_RUN), 32'd1);
  endtask

  initial begin
    RESET_N = 1'b0; START = 1'b0; PAUSE = 1'b0; BALL_H = 11'd400;
    #2;
    chk("rst_state", 32'(STATE), 32'd0);
    chk("rst_tick", 32'(TICK), 32'd0);
    chk("rst_load", 32'(BALL_LOAD), 32'd0);
    chk("rst_run", 32'(BALL_RUN), 32'd0);
    chk("rst_scores", 32'({SCORE_L, SCORE_R}), 32'd0);
    chk("rst_dir_win", 32'({SERVE_DIR, WINNER}), 32'd0);
    #20 RESET_N = 1'b1;

    // Divider: TICK on every 4th cycle after release.
    for (int k = 1; k <= 20; k++) begin
      step();
      chk("idle_tick", 32'(TICK), 32'(k % 4 == 3));
    end
    chk("idle_state", 32'(STATE), 32'd0);
    chk("idle_run", 32'(BALL_RUN), 32'd0);

    // First serve enters on divider count 1: PLAY 11 cycles later.
    START = 1'b1;
    step();
    START = 1'b0;
    chk("start_state", 32'(STATE), 32'd1);
    chk("start_load", 32'(BALL_LOAD), 32'd1);
    step();
    chk("load_pulse_end", 32'(BALL_LOAD), 32'd0);
    step(9);
    chk("serve_wait", 32'(STATE), 32'd1);
    step();
    chk("first_play", 32'(STATE), 32'd2);
    chk("first_run", 32'(BALL_RUN), 32'd1);

    // Just inside both edges: no miss.
    for (int i = 0; i < 4; i++) begin
      BALL_H = (i % 2 == 1) ? 11'd1 : 11'd798;
      step();
      chk("near_edge", 32'(STATE), 32'd2);
    end

    BALL_H = 11'd799;
    step();
    BALL_H = 11'd400;
    chk("rmiss_state", 32'(STATE), 32'd3);
    chk("rmiss_score_l", 32'(SCORE_L), 32'd1);
    chk("rmiss_dir", 32'(SERVE_DIR), 32'd1);
    chk("rmiss_run", 32'(BALL_RUN), 32'd0);
    point_to_serve();
    serve_to_play();

    // Three left misses give the right player the game.
    for (int n = 1; n <= 3; n++) begin
      BALL_H = 11'd0;
      step();
      BALL_H = 11'd400;
      chk("lmiss_state", 32'(STATE), 32'd3);
      chk("lmiss_score_r", 32'(SCORE_R), 32'(n));
      chk("lmiss_dir", 32'(SERVE_DIR), 32'd0);
      if (n < 3) begin
        point_to_serve();
        serve_to_play();
      end
    end
    step();
    chk("over_state", 32'(STATE), 32'd4);
    chk("over_winner", 32'(WINNER), 32'd1);

    BALL_H = 11'd0;
    step(10);
    BALL_H = 11'd400;
    chk("over_hold_r", 32'(SCORE_R), 32'd3);
    chk("over_hold_l", 32'(SCORE_L), 32'd1);
    chk("over_hold_state", 32'(STATE), 32'd4);
    chk("over_hold_win", 32'(WINNER), 32'd1);

    // New game from OVER.
    START = 1'b1;
    step();
    START = 1'b0;
    chk("restart_state", 32'(STATE), 32'd1);
    chk("restart_scores", 32'({SCORE_L, SCORE_R}), 32'd0);
    chk("restart_winner", 32'(WINNER), 32'd0);
    chk("restart_dir", 32'(SERVE_DIR), 32'd0);
    chk("restart_load", 32'(BALL_LOAD), 32'd1);
    step(2);
    chk("pre_pause_tick", 32'(TICK), 32'd1);
    step();

    // One serve tick consumed; pause 50 cycles, then two more ticks needed.
    PAUSE = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("pause_tick", 32'(TICK), 32'd0);
      chk("pause_state", 32'(STATE), 32'd1);
    end
    PAUSE = 1'b0;
    step(2);
    chk("resume_no_tick", 32'(TICK), 32'd0);
    step();
    chk("resume_tick", 32'(TICK), 32'd1);
    step(4);
    chk("resume_serve", 32'(STATE), 32'd1);
    step();
    chk("resume_play", 32'(STATE), 32'd2);

    // START is ignored in PLAY.
    START = 1'b1;
    step();
    START = 1'b0;
    chk("start_in_play", 32'(STATE), 32'd2);
    step(3);
    chk("start_in_play2", 32'(STATE), 32'd2);

    BALL_H = 11'd799;
    step();
    BALL_H = 11'd400;
    chk("g2_score_l1", 32'(SCORE_L), 32'd1);
    point_to_serve();
    serve_to_play();
    BALL_H = 11'd799;
    step();
    BALL_H = 11'd400;
    chk("g2_score_l2", 32'(SCORE_L), 32'd2);
    point_to_serve();
    serve_to_play();
    chk("g2_pre_rst_l", 32'(SCORE_L), 32'd2);

    // Asynchronous reset mid-PLAY.
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_state", 32'(STATE), 32'd0);
    chk("arst_scores", 32'({SCORE_L, SCORE_R}), 32'd0);
    chk("arst_run", 32'(BALL_RUN), 32'd0);
    chk("arst_dir", 32'(SERVE_DIR), 32'd0);
    #5 RESET_N = 1'b1;
    step();
    chk("post_rst_idle", 32'(STATE), 32'd0);
    START = 1'b1;
    step();
    START = 1'b0;
    chk("post_rst_start", 32'(STATE), 32'd1);
    chk("post_rst_load", 32'(BALL_LOAD), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
